// File: rtl/sd_pkg.sv
// Shared definitions for the SD sector read sequencer: FSM encoding and
// default sizing of a sector and of the per-sector watchdog.
package sd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ROOM,
        REQ,
        XFER,
        CHECK,
        DONE,
        ERR
    } sd_state_t;

    localparam int          WORDS_PER_SEC_D = 256;
    localparam logic [23:0] TIMEOUT_CYC_D   = 24'd1_000_000;

endpackage

// File: rtl/sd_rd_seq_if.sv
// Job, sector-reader and downstream-FIFO signals of the read sequencer.
interface sd_rd_seq_if #(
    parameter int ROOM_W = 10
);
    logic              sd_init_done;
    logic              seq_start;
    logic [31:0]       seq_base_addr;
    logic [15:0]       seq_sec_num;
    logic              seq_busy;
    logic              seq_done;
    logic              seq_err;
    logic              rd_start_en;
    logic [31:0]       rd_sec_addr;
    logic              rd_busy;
    logic              rd_val_en;
    logic [15:0]       rd_val_data;
    logic [ROOM_W-1:0] fifo_room;
    logic              wr_en;
    logic [15:0]       wr_data;

    modport slave (
        input  sd_init_done, seq_start, seq_base_addr, seq_sec_num,
        input  rd_busy, rd_val_en, rd_val_data, fifo_room,
        output seq_busy, seq_done, seq_err, rd_start_en, rd_sec_addr,
        output wr_en, wr_data
    );

    modport master (
        output sd_init_done, seq_start, seq_base_addr, seq_sec_num,
        output rd_busy, rd_val_en, rd_val_data, fifo_room,
        input  seq_busy, seq_done, seq_err, rd_start_en, rd_sec_addr,
        input  wr_en, wr_data
    );

endinterface

// File: rtl/sd_timeout_cnt.sv
// Saturating watchdog counter: cleared by i_clr, counts while i_en, and
// flags o_expired once LIMIT cycles have been counted.
module sd_timeout_cnt
    import sd_pkg::*;
#(
    parameter logic [23:0] LIMIT = TIMEOUT_CYC_D
) (
    input  logic clk_ref,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [23:0] r_cnt;

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 24'd1;
        end
    end

    assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/sd_rd_seq.sv
// Multi-sector read sequencer: requests one sector at a time from the reader
// when the downstream FIFO has room, forwards the words, and checks each count.
module sd_rd_seq
    import sd_pkg::*;
#(
    parameter int          WORDS_PER_SEC = WORDS_PER_SEC_D,
    parameter logic [23:0] TIMEOUT_CYC   = TIMEOUT_CYC_D,
    parameter int          ROOM_W        = 10
) (
    input  logic       clk_ref,
    input  logic       rst_n,
    sd_rd_seq_if.slave bus
);

    sd_state_t   r_state, w_nxt;
    logic [31:0] r_addr;
    logic [15:0] r_remaining;
    logic [8:0]  r_word_cnt;
    logic [15:0] r_wr_data;
    logic        r_busy, r_done, r_err, r_rd_start_en, r_wr_en, r_init_lost;
    logic        w_expired, w_active, w_timed, w_accept, w_room_ok, w_sec_ok;
    logic        w_stray, w_take;

    assign w_active  = (r_state == WAIT_ROOM) || (r_state == REQ) ||
                       (r_state == XFER) || (r_state == CHECK);
    assign w_timed   = (r_state == REQ) || (r_state == XFER);
    assign w_accept  = ((r_state == IDLE) || (r_state == ERR)) &&
                       bus.seq_start && bus.sd_init_done;
    assign w_room_ok = ({{(32-ROOM_W){1'b0}}, bus.fifo_room} >= 32'(WORDS_PER_SEC));
    assign w_sec_ok  = (r_word_cnt == 9'(WORDS_PER_SEC));
    assign w_take    = bus.rd_val_en && (r_state == XFER);
    // Words arriving outside a transfer are discarded; only a running job cares.
    assign w_stray   = bus.rd_val_en && w_active && (r_state != XFER);

    sd_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_timeout (
        .clk_ref   (clk_ref),
        .rst_n     (rst_n),
        .i_clr     (!w_timed),
        .i_en      (w_timed),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE, ERR: if (w_accept) w_nxt = WAIT_ROOM;
            WAIT_ROOM: begin
                if (r_remaining == 16'd0)                       w_nxt = DONE;
                else if (r_init_lost || !bus.sd_init_done)      w_nxt = ERR;
                else if (w_room_ok && !bus.rd_busy)             w_nxt = REQ;
            end
            REQ: begin
                if (w_expired)        w_nxt = ERR;
                else if (bus.rd_busy) w_nxt = XFER;
            end
            XFER: begin
                if (w_expired)         w_nxt = ERR;
                else if (!bus.rd_busy) w_nxt = CHECK;
            end
            CHECK: begin
                if (!w_sec_ok || r_init_lost || !bus.sd_init_done) w_nxt = ERR;
                else                                                w_nxt = WAIT_ROOM;
            end
            DONE:    w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they never glitch.
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_rd_start_en <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_data     <= '0;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_word_cnt    <= '0;
            r_init_lost   <= 1'b0;
        end else begin
            r_busy        <= (w_nxt inside {WAIT_ROOM, REQ, XFER, CHECK});
            r_done        <= (w_nxt == DONE);
            r_rd_start_en <= (w_nxt == REQ);
            r_wr_en       <= w_take;
            if (w_take) r_wr_data <= bus.rd_val_data;

            if (w_accept) begin
                r_addr      <= bus.seq_base_addr;
                r_remaining <= bus.seq_sec_num;
                r_err       <= 1'b0;
                r_init_lost <= 1'b0;
            end else begin
                if (((w_nxt == ERR) && (r_state != ERR)) || w_stray) r_err <= 1'b1;
                if (w_active && !bus.sd_init_done) r_init_lost <= 1'b1;
                if ((r_state == CHECK) && w_sec_ok) begin
                    r_addr      <= r_addr + 32'd1;
                    r_remaining <= r_remaining - 16'd1;
                end
            end

            if (r_state == REQ)  r_word_cnt <= '0;
            else if (w_take)     r_word_cnt <= r_word_cnt + 9'd1;
        end
    end

    assign bus.seq_busy    = r_busy;
    assign bus.seq_done    = r_done;
    assign bus.seq_err     = r_err;
    assign bus.rd_start_en = r_rd_start_en;
    assign bus.rd_sec_addr = r_addr;
    assign bus.wr_en       = r_wr_en;
    assign bus.wr_data     = r_wr_data;

endmodule

// File: doc/sd_rd_seq.md
SD_RD_SEQ -- requirements
Module: sd_rd_seq

Interface
REQ-001 Parameter: WORDS_PER_SEC, 256, 16-bit words per 512-byte sector.
REQ-002 Parameter: TIMEOUT_CYC, 24'd1_000_000, maximum clk_ref cycles from request to sector completion.
REQ-003 Parameter: ROOM_W, 10, width of the fifo_room input.
REQ-004 Port: clk_ref  in  1  single system clock; all logic on its rising edge.
REQ-005 Port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Port: sd_init_done  in  1  SD card initialised; a job shall not start while this is low.
REQ-007 Port: seq_start  in  1  one-cycle job request pulse.
REQ-008 Port: seq_base_addr  in  32  first sector address of the job.
REQ-009 Port: seq_sec_num  in  16  sector count of the job; 0 is legal and means an empty job.
REQ-010 Port: seq_busy  out  1  high while a job is active.
REQ-011 Port: seq_done  out  1  one-cycle pulse when a job completes successfully.
REQ-012 Port: seq_err  out  1  sticky error flag; cleared by the next accepted seq_start.
REQ-013 Port: rd_start_en  out  1  level request to the sector reader.
REQ-014 Port: rd_sec_addr  out  32  sector address sent to the reader.
REQ-015 Port: rd_busy  in  1  reader busy flag.
REQ-016 Port: rd_val_en, rd_val_data  in  1/16  reader word strobe and word.
REQ-017 Port: fifo_room  in  ROOM_W  free word count of the downstream FIFO.
REQ-018 Port: wr_en, wr_data  out  1/16  downstream FIFO write strobe and word.

Function
REQ-019 The FSM shall have these states: IDLE, WAIT_ROOM, REQ, XFER, CHECK, DONE, ERR.
REQ-020 IDLE: when seq_start=1 and sd_init_done=1, the block shall latch addr=seq_base_addr and remaining=seq_sec_num, clear seq_err, set seq_busy=1, and go to WAIT_ROOM; seq_start while busy or while sd_init_done=0 shall be ignored.
REQ-021 WAIT_ROOM: if remaining==0, go to DONE; otherwise, when fifo_room>=WORDS_PER_SEC and rd_busy=0, go to REQ.
REQ-022 REQ: drive rd_start_en=1 and rd_sec_addr=addr, clear word_cnt and the timeout counter, and hold until rd_busy=1 is seen, then drop rd_start_en and go to XFER; rd_start_en shall be low for at least 2 cycles before each assertion so the reader sees a rising edge.
REQ-023 XFER: each rd_val_en shall produce wr_en=1 and wr_data=rd_val_data on the next cycle (1-cycle registered latency) and increment word_cnt (9 bit); on rd_busy falling, go to CHECK.
REQ-024 CHECK: if word_cnt==WORDS_PER_SEC, addr+=1 (32-bit wrap from FFFF_FFFF to 0 is allowed) and remaining-=1, then go to WAIT_ROOM; otherwise set seq_err=1 and go to ERR.
REQ-025 The timeout counter shall run in REQ and XFER; when it reaches TIMEOUT_CYC, set seq_err=1 and go to ERR.
REQ-026 ERR: hold rd_start_en=0 and seq_busy=0, and stay until the next accepted seq_start (same rules as IDLE).
REQ-027 DONE: pulse seq_done=1 for one cycle, set seq_busy=0, and return to IDLE.
REQ-028 An rd_val_en outside XFER shall be dropped (no wr_en) and shall set seq_err only when the FSM is busy.
REQ-029 If sd_init_done falls mid-job, the current sector shall finish; the block shall then go to ERR with seq_err=1 instead of WAIT_ROOM.

Reset
REQ-030 On rst_n=0, asynchronously: state=IDLE; seq_busy, seq_done, seq_err, rd_start_en, wr_en=0; rd_sec_addr, wr_data, addr, remaining, word_cnt, timeout=0.
REQ-031 rd_start_en shall never glitch high on reset release.

Structure
REQ-032 The state encoding and the WORDS_PER_SEC/TIMEOUT_CYC defaults shall live in the shared package sd_pkg.
REQ-033 The timeout counter shall be one sub-module, sd_timeout_cnt (clear, enable, expired output); everything else shall be flat.

Verification
REQ-034 Directed test: base=0x0000_2000, num=3, fifo_room=512, reader model 256 words/sector -> rd_sec_addr 0x2000, 0x2001, 0x2002; 768 wr_en; one seq_done; seq_err=0.
REQ-035 Directed test: num=0 -> seq_done 2 cycles after seq_start; rd_start_en never high.
REQ-036 Directed test: fifo_room=255 held for 100 cycles, then 256 -> no rd_start_en until room=256; request within 2 cycles after.
REQ-037 Directed test: reader returns 255 words -> seq_err=1; no further requests; a new seq_start clears seq_err.
REQ-038 Directed test: reader never raises rd_busy, TIMEOUT_CYC=1000 -> seq_err=1 at cycle ~1000; rd_start_en low.
REQ-039 Directed test: rst_n low mid-XFER (word 100) -> all outputs 0 immediately; after release, a fresh job with base=0xFFFF_FFFF, num=2 wraps the address to 0x0000_0000.
